mix_columns_seq: RTL and testbench

Column-serial AES MixColumns stage for the encryption round datapath. It sits after ShiftRows and before AddRoundKey. It accepts one 128-bit state, processes one 32-bit column per clock using four `mulby2` xtime instances, and presents the mixed state through a valid/ready handshake. A per-transaction bypass passes the state through unchanged for the final AES round, which has no MixColumns.

---
 rtl/mix_columns_seq.sv | 120 ++++++++++++
 tb/tb_mix_columns_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_seq.sv
// Column-serial AES MixColumns stage with per-transaction bypass.
// Ports:
//   clk, rst             clock and asynchronous active-high reset
//   in[127:0]            input state, FIPS-197 byte order (column 0 in the MSBs)
//   in_valid, in_ready   input handshake; in_ready is high only in IDLE
//   last_round           sampled with in; 1 passes the state through unchanged
//   out[127:0]           registered mixed state, same byte order as in
//   out_valid, out_ready output handshake; out is held stable while out_valid is high

// GF(2^8) multiply by 2 (xtime).
module mulby2 (
    input  logic [7:0] x,
    output logic [7:0] y
);
    assign y = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
endmodule

module mix_columns_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] in,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         last_round,
    output logic [127:0] out,
    output logic         out_valid,
    input  logic         out_ready
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]   state;
    logic [1:0]   state_nxt;
    logic [1:0]   col;
    logic [127:0] st;
    logic         bypass;
    logic [31:0]  a_col;
    logic [7:0]   a0, a1, a2, a3;
    logic [7:0]   m0, m1, m2, m3;
    logic [31:0]  mix_col;

    // Column col of the captured state.
    always_comb begin
        a_col = st[127:96];
        case (col)
            2'd0:    a_col = st[127:96];
            2'd1:    a_col = st[95:64];
            2'd2:    a_col = st[63:32];
            default: a_col = st[31:0];
        endcase
    end

    assign a0 = a_col[31:24];
    assign a1 = a_col[23:16];
    assign a2 = a_col[15:8];
    assign a3 = a_col[7:0];

    mulby2 u_m0 (.x(a0), .y(m0));
    mulby2 u_m1 (.x(a1), .y(m1));
    mulby2 u_m2 (.x(a2), .y(m2));
    mulby2 u_m3 (.x(a3), .y(m3));

    // 3*x is formed as 2*x ^ x.
    assign mix_col = {m0 ^ (m1 ^ a1) ^ a2 ^ a3,
                      a0 ^ m1 ^ (m2 ^ a2) ^ a3,
                      a0 ^ a1 ^ m2 ^ (m3 ^ a3),
                      (m0 ^ a0) ^ a1 ^ a2 ^ m3};

    // Next-state decode. A bypass transaction spends one BUSY cycle loading the
    // captured state into out, which gives it a one-cycle latency after accept.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = BUSY;
            BUSY:    if (bypass || col == 2'd3) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture, column-serial result write and bypass load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st     <= 128'h0;
            bypass <= 1'b0;
            col    <= 2'd0;
            out    <= 128'h0;
        end else begin
            if (state == IDLE && in_valid) begin
                st     <= in;
                bypass <= last_round;
                col    <= 2'd0;
            end else if (state == BUSY) begin
                if (bypass) begin
                    out <= st;
                end else begin
                    case (col)
                        2'd0:    out[127:96] <= mix_col;
                        2'd1:    out[95:64]  <= mix_col;
                        2'd2:    out[63:32]  <= mix_col;
                        default: out[31:0]   <= mix_col;
                    endcase
                    col <= col + 2'd1;
                end
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq: GF(2^8) matrix model, scoreboard
// compare on every valid cycle, and directed vectors with literal expectations.
module tb_mix_columns_seq;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] din = 128'h0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         last_round = 1'b0;
    logic [127:0] dout;
    logic         out_valid;
    logic         out_ready = 1'b1;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int acc_cyc = 0;
    logic [127:0] exp_q[$];
    int           lat_q[$];
    logic         prev_valid = 1'b0;

    mix_columns_seq dut (
        .clk(clk), .rst(rst), .in(din), .in_valid(in_valid), .in_ready(in_ready),
        .last_round(last_round), .out(dout), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Full GF(2^8) multiply, shift-and-add with AES reduction polynomial.
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] a = a_in;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // MixColumns as the circulant matrix [2 3 1 1] applied to each column.
    function automatic logic [127:0] mix(input logic [127:0] d);
        logic [127:0] o = 128'h0;
        logic [7:0]   cf[4] = '{8'd2, 8'd3, 8'd1, 8'd1};
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                logic [7:0] acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc ^= gmul(cf[(k - r + 4) % 4], d[127 - 8 * (4 * c + k) -: 8]);
                o[127 - 8 * (4 * c + r) -: 8] = acc;
            end
        end
        return o;
    endfunction

    // Scoreboard compare: every cycle out_valid is high, plus latency on the rise.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid <= 1'b0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 128'(out_valid), 128'h0);
                end else begin
                    if (!prev_valid) check("latency", 128'(cyc - acc_cyc), 128'(lat_q[0]));
                    check("out_data", dout, exp_q[0]);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        void'(lat_q.pop_front());
                    end
                end
            end
            prev_valid <= out_valid;
        end
    end

    // Present one state; optionally churn the inputs during the BUSY cycles.
    task automatic send(input logic [127:0] d, input logic lr, input bit churn);
        int n = 0;
        @(negedge clk);
        din = d; last_round = lr; in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 128'(in_ready), 128'h1);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(lr ? d : mix(d));
        lat_q.push_back(lr ? 1 : 4);
        acc_cyc = cyc + 1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (churn) begin
            for (int k = 0; k < (lr ? 1 : 3); k++) begin
                din = {$urandom, $urandom, $urandom, $urandom};
                last_round = 1'($urandom);
                in_valid = 1'($urandom);
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
        end
    endtask

    // Wait for return to IDLE and check the cycle at which in_ready is back.
    task automatic wait_idle(input int exp_gap, input bit check_gap);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("idle_timeout", 128'(in_ready), 128'h1);
        else if (check_gap) check("in_ready_return", 128'(cyc - acc_cyc), 128'(exp_gap));
    endtask

    initial begin
        logic [127:0] v;
        logic [127:0] hold;
        int n;

        // Model pinned against hand-computed literals.
        check("model_fips_r1", mix(128'hd4bf5d30e0b452aeb84111f11e2798e5),
              128'h046681e5e0cb199a48f8d37a2806264c);
        check("model_cols", mix(128'hdb135345f20a225c01010101c6c6c6c6),
              128'h8e4da1bc9fdc589d01010101c6c6c6c6);
        check("model_d4", mix(128'hd4d4d4d5d4d4d4d5d4d4d4d5d4d4d4d5),
              128'hd5d5d7d6d5d5d7d6d5d5d7d6d5d5d7d6);

        #12;
        check("reset_out", dout, 128'h0);
        check("reset_out_valid", 128'(out_valid), 128'h0);
        check("reset_in_ready", 128'(in_ready), 128'h1);
        @(negedge clk); rst = 1'b0;

        // FIPS-197 round 1 with out_ready held high.
        send(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 1'b0);
        wait_idle(5, 1'b1);

        // Known columns, exercising the 0x1b reduction.
        send(128'hdb135345f20a225c01010101c6c6c6c6, 1'b0, 1'b0);
        wait_idle(5, 1'b1);

        // Bypass: out must not change before the single load.
        hold = dout;
        send(128'h00112233445566778899aabbccddeeff, 1'b1, 1'b0);
        @(negedge clk);
        check("bypass_hold", dout, hold);
        @(negedge clk);
        check("bypass_out", dout, 128'h00112233445566778899aabbccddeeff);
        wait_idle(2, 1'b1);

        // Backpressure: hold out for 10 cycles with a competing input.
        @(posedge clk); #1; out_ready = 1'b0;
        send(128'h0102030405060708090a0b0c0d0e0f10, 1'b0, 1'b0);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", 128'(out_valid), 128'h1);
        din = 128'hffffffffffffffffffffffffffffffff; in_valid = 1'b1; last_round = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_in_ready_low", 128'(in_ready), 128'h0);
            check("bp_out_valid", 128'(out_valid), 128'h1);
        end
        in_valid = 1'b0;
        @(posedge clk); #1; out_ready = 1'b1;
        wait_idle(0, 1'b0);
        send(128'h63636363_7c7c7c7c_77777777_7b7b7b7b, 1'b0, 1'b0);
        wait_idle(5, 1'b1);

        // Reset after edge E+2 of a normal transaction.
        send(128'hdb135345db135345db135345db135345, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_mid_out", dout, 128'h0);
        check("rst_mid_out_valid", 128'(out_valid), 128'h0);
        check("rst_mid_in_ready", 128'(in_ready), 128'h1);
        exp_q.delete();
        lat_q.delete();
        @(negedge clk); rst = 1'b0;
        send(128'hd4d4d4d5d4d4d4d5d4d4d4d5d4d4d4d5, 1'b0, 1'b0);
        wait_idle(5, 1'b1);
        check("rst_follow_out", dout, 128'hd5d5d7d6d5d5d7d6d5d5d7d6d5d5d7d6);

        // Input churn over random states; scoreboard checks each result.
        for (int t = 0; t < 1000; t++) begin
            v = {$urandom, $urandom, $urandom, $urandom};
            send(v, 1'($urandom_range(0, 7) == 0), 1'b1);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", 128'(exp_q.size()), 128'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
